i2c_master_arbiter: RTL and testbench

//  Shares a single I2C_master write engine between NUM_REQ requesters (e.g. sensor init, runtime config).

---
 rtl/i2c_master_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_master_arbiter
//
// Shares one I2C write engine (I2C_master) between NUM_REQ requesters.
// A round-robin pointer picks the next requester, the winner's slave address,
// register address and write data are latched into registered m_* outputs,
// and the start/ready handshake with the master is sequenced by an FSM:
//
//   IDLE -> LOAD -> ISSUE -> BUSY -> DONE -> IDLE
//
// The block runs in the I2C_master clock domain and shares its reset.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   TIMEOUT_CYC  watchdog limit in clk cycles (used with I2C_ARB_TIMEOUT_EN)
//
// Optional feature
//   `define I2C_ARB_TIMEOUT_EN  adds a watchdog over ISSUE/BUSY; on expiry the
//   owner gets an err pulse instead of done and the arbiter returns to IDLE.
//   Without it, err is tied to 0 and the arbiter waits on m_ready forever.
//
// Ports
//   clk       in   single clock, same as I2C_master
//   reset     in   synchronous, active-high
//   req       in   [NUM_REQ]     level requests, held until done/err
//   req_addr  in   [7*NUM_REQ]   7-bit slave address per requester
//   req_sub   in   [8*NUM_REQ]   register (sub) address per requester
//   req_data  in   [8*NUM_REQ]   write data per requester
//   grant     out  [NUM_REQ]     one-hot current owner, 0 when idle
//   done      out  [NUM_REQ]     1-cycle completion pulse on owner's bit
//   err       out  [NUM_REQ]     1-cycle timeout pulse on owner's bit
//   m_start   out                start strobe to I2C_master
//   m_addr    out  [7]           latched slave address to I2C_master
//   m_sub     out  [8]           latched register address to I2C_master
//   m_data    out  [8]           latched write data to I2C_master
//   m_ready   in                 I2C_master idle indication
// -----------------------------------------------------------------------------
module i2c_master_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_sub,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic                   m_start,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_sub,
    output logic [7:0]             m_data,
    input  logic                   m_ready
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time guard on the supported configuration range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("i2c_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;      // highest-priority requester for next arbitration
    logic [PTR_W-1:0] owner;    // index of the current grant holder
    logic [PTR_W-1:0] win_idx;
    logic             win_found;

    // First set request bit at or after p, wrapping modulo NUM_REQ.
    // Returns {found, index}.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [PTR_W-1:0]   p);
        int   idx;
        logic found;
        found   = 1'b0;
        rr_pick = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(p) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && r[idx]) begin
                found   = 1'b1;
                rr_pick = {1'b1, idx[PTR_W-1:0]};
            end
        end
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] o);
        return (int'(o) == NUM_REQ - 1) ? '0 : o + PTR_W'(1);
    endfunction

    assign {win_found, win_idx} = rr_pick(req, ptr);

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expired;

    // wd_cnt is 0 in the first ISSUE cycle, so hitting TIMEOUT_CYC-1 here
    // means the TIMEOUT_CYC-th cycle spent in ISSUE/BUSY.
    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign err = '0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below sees the pre-edge values of state, grant and owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant   <= '0;
            done    <= '0;
            m_start <= 1'b0;
            m_addr  <= '0;
            m_sub   <= '0;
            m_data  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err     <= '0;
            wd_cnt  <= '0;
`endif
        end else begin
            // done/err are single-cycle pulses; only a transition re-arms them.
            done <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err  <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (win_found && m_ready) begin
                        grant  <= NUM_REQ'(1) << win_idx;
                        owner  <= win_idx;
                        m_addr <= req_addr[7*int'(win_idx) +: 7];
                        m_sub  <= req_sub[8*int'(win_idx) +: 8];
                        m_data <= req_data[8*int'(win_idx) +: 8];
                        state  <= S_LOAD;
                    end
                end

                // Gives the master one cycle of stable m_* before start.
                S_LOAD: begin
                    m_start <= 1'b1;
                    state   <= S_ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_cnt  <= '0;
`endif
                end

                // Master signals acceptance by dropping ready.
                S_ISSUE: begin
                    if (!m_ready) begin
                        m_start <= 1'b0;
                        state   <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    if (m_ready) begin
                        done  <= grant;
                        grant <= '0;
                        ptr   <= next_ptr(owner);
                        state <= S_DONE;
                    end
                end

                // done is high during this cycle; arbitration resumes in IDLE.
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

`ifdef I2C_ARB_TIMEOUT_EN
            // Placed after the case so an expiry overrides any progress the
            // case scheduled in the same cycle (last non-blocking write wins).
            if (state == S_ISSUE || state == S_BUSY) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
                if (wd_expired) begin
                    err     <= grant;
                    done    <= '0;
                    grant   <= '0;
                    m_start <= 1'b0;
                    ptr     <= next_ptr(owner);
                    state   <= S_IDLE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_arbiter
//
// Self-checking bench for i2c_master_arbiter (NUM_REQ=4, TIMEOUT_CYC=16).
// A small behavioural I2C_master drives m_ready. Expected transfers are pushed
// to a scoreboard when requests are driven; a monitor pops and compares them
// when m_start rises, and checks done/err pulses against the current owner.
// -----------------------------------------------------------------------------
module tb_i2c_master_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int BUSY_LEN = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_sub;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant, done, err;
    logic                 m_start;
    logic [6:0]           m_addr;
    logic [7:0]           m_sub, m_data;
    logic                 m_ready;

    logic mdl_ready  = 1'b1;
    logic force_low  = 1'b0;
    logic stuck      = 1'b0;
    int   busy_cnt   = 0;

    logic [6:0] t_addr [NUM_REQ];
    logic [7:0] t_sub  [NUM_REQ];
    logic [7:0] t_data [NUM_REQ];

    typedef struct {
        int         idx;
        logic [6:0] a;
        logic [7:0] s;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_sub  (req_sub),
        .req_data (req_data),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_sub    (m_sub),
        .m_data   (m_data),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    assign m_ready = mdl_ready && !force_low;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[7*i +: 7] = t_addr[i];
            req_sub[8*i +: 8]  = t_sub[i];
            req_data[8*i +: 8] = t_data[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural I2C_master: accepts start while idle, stays busy BUSY_LEN
    // cycles (forever while stuck), then returns ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mdl_ready = 1'b1;
                busy_cnt  = 0;
            end else if (mdl_ready) begin
                if (m_start) begin
                    mdl_ready = 1'b0;
                    busy_cnt  = BUSY_LEN;
                end
            end else if (!stuck) begin
                if (busy_cnt == 0) mdl_ready = 1'b1;
                else busy_cnt--;
            end
        end
    end

    // Monitor: scoreboard compare on m_start rise, pulse checks on done/err.
    initial begin
        logic               prev_start;
        logic [NUM_REQ-1:0] prev_done;
        logic [NUM_REQ-1:0] owner_q;
        exp_t               e;
        prev_start = 1'b0;
        prev_done  = '0;
        owner_q    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_start = 1'b0;
                prev_done  = '0;
                owner_q    = '0;
            end else begin
                if (m_start && !prev_start) begin
                    check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("grant_order", 32'(grant), 32'(1) << e.idx);
                        check("m_addr", 32'(m_addr), 32'(e.a));
                        check("m_sub", 32'(m_sub), 32'(e.s));
                        check("m_data", 32'(m_data), 32'(e.d));
                    end
                    owner_q = grant;
                end
                if (done != '0) begin
                    check("done_owner", 32'(done), 32'(owner_q));
                    check("done_grant_zero", 32'(grant), 32'(0));
                    done_cnt++;
                end
                if (prev_done != '0) check("done_one_cycle", 32'(done), 32'(0));
                if (err != '0) begin
                    check("err_owner", 32'(err), 32'(owner_q));
                    err_cnt++;
                end
                prev_start = m_start;
                prev_done  = done;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_xfer(input int i);
        sb.push_back('{i, t_addr[i], t_sub[i], t_data[i]});
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_done", 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_busy(input int i);
        int   n  = 0;
        logic ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = grant[i] && !m_start && !m_ready;
            n++;
        end
        check("reach_busy", 32'(ok), 32'(1));
    endtask

    initial begin
        int base;
        int n;

        for (int i = 0; i < NUM_REQ; i++) begin
            t_addr[i] = 7'(8'h10 + i);
            t_sub[i]  = 8'(8'h20 + i);
            t_data[i] = 8'(8'h30 + i);
        end
        t_addr[0] = 7'h55;
        t_sub[0]  = 8'hAA;
        t_data[0] = 8'hAA;

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_m_start", 32'(m_start), 32'(0));
        check("rst_m_addr", 32'(m_addr), 32'(0));
        check("rst_m_sub", 32'(m_sub), 32'(0));
        check("rst_m_data", 32'(m_data), 32'(0));

        // 1: single requester, start latency, done pulse, m_* hold
        base = done_cnt;
        expect_xfer(0);
        req = 4'b0001;
        @(negedge clk);
        check("lat_load_start", 32'(m_start), 32'(0));
        check("lat_load_grant", 32'(grant), 32'(4'b0001));
        @(negedge clk);
        check("lat_issue_start", 32'(m_start), 32'(1));
        wait_dones(base + 1);
        req = '0;
        repeat (4) @(negedge clk);
        check("idle_grant", 32'(grant), 32'(0));
        check("hold_m_addr", 32'(m_addr), 32'(7'h55));
        check("hold_m_data", 32'(m_data), 32'(8'hAA));

        // 2: all requesting -> 0,1,2,3,0
        do_reset();
        base = done_cnt;
        expect_xfer(0); expect_xfer(1); expect_xfer(2); expect_xfer(3); expect_xfer(0);
        req = 4'b1111;
        wait_dones(base + 5);
        req = '0;
        repeat (4) @(negedge clk);
        check("rr_drained", 32'(sb.size()), 32'(0));

        // 3: owner drops req during BUSY
        do_reset();
        base = done_cnt;
        expect_xfer(2); expect_xfer(3);
        req = 4'b1100;
        wait_busy(2);
        req[2] = 1'b0;
        wait_dones(base + 2);
        req = '0;
        repeat (4) @(negedge clk);
        check("drop_drained", 32'(sb.size()), 32'(0));

        // 4: reset in BUSY clears outputs and pointer
        do_reset();
        base = done_cnt;
        expect_xfer(0); expect_xfer(1);
        req = 4'b0011;
        wait_dones(base + 1);
        req = 4'b0010;
        wait_busy(1);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check("rb_grant", 32'(grant), 32'(0));
        check("rb_m_start", 32'(m_start), 32'(0));
        check("rb_done", 32'(done), 32'(0));
        check("rb_m_addr", 32'(m_addr), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        base = done_cnt;
        expect_xfer(0);
        req = 4'b0011;
        wait_dones(base + 1);
        req = '0;
        repeat (4) @(negedge clk);
        check("rb_ptr_drained", 32'(sb.size()), 32'(0));

        // 5: master busy at request time
        do_reset();
        base = done_cnt;
        force_low = 1'b1;
        expect_xfer(0);
        req = 4'b0001;
        repeat (6) @(negedge clk);
        check("nr_grant", 32'(grant), 32'(0));
        check("nr_m_start", 32'(m_start), 32'(0));
        force_low = 1'b0;
        wait_dones(base + 1);
        req = '0;
        repeat (4) @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
        // 6: master stuck after start -> err 16 cycles after ISSUE entry
        do_reset();
        stuck = 1'b1;
        expect_xfer(1);
        req = 4'b0010;
        n = 0;
        while (!m_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("to_start", 32'(m_start), 32'(1));
        n = 0;
        while (err == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 32'(n), 32'(16));
        check("to_err", 32'(err), 32'(4'b0010));
        check("to_grant", 32'(grant), 32'(0));
        check("to_m_start", 32'(m_start), 32'(0));
        req   = '0;
        stuck = 1'b0;
        repeat (10) @(negedge clk);
        check("to_err_count", 32'(err_cnt), 32'(1));
`else
        check("no_err_count", 32'(err_cnt), 32'(0));
`endif

        check("sb_final", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
